// File: rtl/mem_bus_arbiter.sv
// Single-owner arbiter between instruction fetch and data memory ports onto one
// SRAM-like bus. It holds one transaction at a time, and data has priority over fetch.
module mem_bus_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  output logic [DW-1:0] inst_rdata,
  output logic          inst_ok,
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [1:0]    data_size,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic [DW-1:0] data_rdata,
  output logic          data_ok,
  output logic          stall,
  output logic          bus_req,
  output logic          bus_wr,
  output logic [1:0]    bus_size,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_addr_ok,
  input  logic          bus_data_ok,
  input  logic [DW-1:0] bus_rdata,
  output logic [1:0]    dbg_state,
  output logic          dbg_own
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t        state_q;
  logic          own_q;
  logic          wr_q;
  logic [1:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  // Handshake: a requester holds req and its fields steady until its ok pulse.
  // The bus accepts the address phase when bus_req & bus_addr_ok are both high.
  // It completes the transaction with bus_data_ok, which is honoured only in WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      own_q   <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (data_req) begin
            own_q   <= 1'b1;
            wr_q    <= data_wr;
            size_q  <= data_size;
            addr_q  <= data_addr;
            wdata_q <= data_wdata;
            state_q <= ADDR;
          end else if (inst_req) begin
            own_q   <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'd2;
            addr_q  <= inst_addr;
            state_q <= ADDR;
          end
        end
        ADDR: if (bus_addr_ok) state_q <= WAIT;
        WAIT: if (bus_data_ok) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_req   = (state_q == ADDR);
  assign bus_wr    = wr_q;
  assign bus_size  = size_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;

  // Completion is same-cycle so stall drops on the edge the pipeline advances.
  assign inst_ok    = (state_q == WAIT) && bus_data_ok && !own_q;
  assign data_ok    = (state_q == WAIT) && bus_data_ok && own_q;
  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;
  assign stall      = (inst_req && !inst_ok) || (data_req && !data_ok);

  assign dbg_state = state_q;
  assign dbg_own   = own_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a table of request scenarios is played against a
// scripted bus slave, and there are hand sequences for spurious handshakes and reset mid-transaction.
module tb_mem_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int W  = 1 + 2 + AW + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_req, data_req, data_wr;
  logic [AW-1:0] inst_addr, data_addr;
  logic [DW-1:0] data_wdata, bus_rdata;
  logic [1:0]    data_size;
  logic          bus_addr_ok, bus_data_ok;
  logic [DW-1:0] inst_rdata, data_rdata, bus_wdata;
  logic          inst_ok, data_ok, stall, bus_req, bus_wr, dbg_own;
  logic [1:0]    bus_size, dbg_state;
  logic [AW-1:0] bus_addr;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ok(inst_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ok(data_ok),
    .stall(stall), .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .dbg_state(dbg_state), .dbg_own(dbg_own)
  );

  typedef struct {
    logic          ir;
    logic          dr;
    logic          wr;
    logic [1:0]    size;
    logic [AW-1:0] ia;
    logic [AW-1:0] da;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;
    int            aw;
    int            dw;
  } vec_t;

  vec_t          vecs[10];
  logic [W-1:0]  exp_q[$];
  logic          own_q[$];
  logic [DW-1:0] rd_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int            cyc, ad, dd, n, phases, last;
    logic          sl_ph, ip, dp, exp_i, exp_d;
    exp_q.delete(); own_q.delete(); rd_q.delete();
    n = 0;
    if (v.dr) begin
      exp_q.push_back({v.wr, v.size, v.da, v.wd});
      own_q.push_back(1'b1);
      rd_q.push_back(v.rd ^ 32'h5A5A_5A5A);
      n++;
    end
    if (v.ir) begin
      exp_q.push_back({1'b0, 2'd2, v.ia, {DW{1'b0}}});
      own_q.push_back(1'b0);
      rd_q.push_back(v.rd);
      n++;
    end
    @(posedge clk); #1;
    inst_req = v.ir; inst_addr = v.ia;
    data_req = v.dr; data_wr = v.wr; data_size = v.size; data_addr = v.da; data_wdata = v.wd;
    ip = v.ir; dp = v.dr;
    cyc = 0; ad = 0; dd = 0; sl_ph = 1'b0; phases = 0; last = -1;
    while ((ip || dp) && cyc < 300) begin
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = $urandom;
      if (sl_ph) begin
        if (dd == v.dw) begin bus_data_ok = 1'b1; bus_rdata = rd_q[0]; end
        dd++;
      end else if (bus_req) begin
        if (ad == v.aw) bus_addr_ok = 1'b1;
        ad++;
      end
      @(negedge clk);
      if (bus_req) begin
        if (exp_q.size() == 0) begin
          check("extra_addr_phase", bus_req, 1'b0);
        end else begin
          check("bus_wr", bus_wr, exp_q[0][W-1]);
          check("bus_size", bus_size, exp_q[0][W-2 -: 2]);
          check("bus_addr", bus_addr, exp_q[0][AW+DW-1 -: AW]);
          if (own_q[0]) check("bus_wdata", bus_wdata, exp_q[0][DW-1:0]);
          check("owner", dbg_own, own_q[0]);
          if (bus_addr_ok) begin
            void'(exp_q.pop_front());
            sl_ph = 1'b1; dd = 0; ad = 0; phases++;
          end
        end
      end
      exp_i = 1'b0; exp_d = 1'b0;
      if (bus_data_ok) begin exp_i = !own_q[0]; exp_d = own_q[0]; end
      check("inst_ok", inst_ok, exp_i);
      check("data_ok", data_ok, exp_d);
      check("stall", stall, (ip && !exp_i) || (dp && !exp_d));
      if (bus_data_ok) begin
        if (exp_i) check("inst_rdata", inst_rdata, rd_q[0]);
        else       check("data_rdata", data_rdata, rd_q[0]);
        void'(own_q.pop_front()); void'(rd_q.pop_front());
        sl_ph = 1'b0; last = cyc;
        if (exp_i) ip = 1'b0; else dp = 1'b0;
      end
      @(posedge clk); #1;
      inst_req = ip; data_req = dp; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
      cyc++;
    end
    check($sformatf("done_in_budget_v%0d", idx), ip || dp, 1'b0);
    check($sformatf("addr_phases_v%0d", idx), phases, n);
    check($sformatf("latency_v%0d", idx), last, n * (2 + v.aw + v.dw) + (n - 1));
    check($sformatf("idle_after_v%0d", idx), dbg_state, 2'd0);
  endtask

  initial begin
    vecs[0] = '{ir:1'b1, dr:1'b0, wr:1'b0, size:2'd2, ia:32'hBFC0_0000, da:32'h0,
                wd:32'h0, rd:32'h2408_0001, aw:0, dw:1};
    vecs[0].dw = 0;
    vecs[1] = '{ir:1'b1, dr:1'b1, wr:1'b0, size:2'd2, ia:32'hBFC0_0010, da:32'h8000_1000,
                wd:32'hDEAD_BEEF, rd:32'h1111_2222, aw:0, dw:0};
    vecs[2] = '{ir:1'b0, dr:1'b1, wr:1'b1, size:2'd0, ia:32'h0, da:32'h8000_0003,
                wd:32'h0000_00AB, rd:32'h0, aw:3, dw:0};
    vecs[3] = '{ir:1'b1, dr:1'b0, wr:1'b0, size:2'd2, ia:32'hBFC0_0100, da:32'h0,
                wd:32'h0, rd:32'hCAFE_F00D, aw:0, dw:5};
    vecs[4] = '{ir:1'b1, dr:1'b1, wr:1'b1, size:2'd1, ia:32'h0040_0020, da:32'h8000_2002,
                wd:32'h0000_1234, rd:32'h7777_0000, aw:1, dw:2};
    vecs[5] = '{ir:1'b0, dr:1'b1, wr:1'b0, size:2'd2, ia:32'h0, da:32'h8000_0ABC,
                wd:32'h0, rd:32'h0BAD_C0DE, aw:2, dw:1};
    for (int i = 6; i < 10; i++) begin
      vecs[i].ir   = 1'($urandom_range(0, 1));
      vecs[i].dr   = vecs[i].ir ? 1'($urandom_range(0, 1)) : 1'b1;
      vecs[i].wr   = 1'($urandom_range(0, 1));
      vecs[i].size = 2'($urandom_range(0, 2));
      vecs[i].ia   = $urandom;
      vecs[i].da   = $urandom;
      vecs[i].wd   = $urandom;
      vecs[i].rd   = $urandom;
      vecs[i].aw   = $urandom_range(0, 3);
      vecs[i].dw   = $urandom_range(0, 4);
    end

    rst = 1'b0;
    inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0;
    inst_addr = '0; data_addr = '0; data_wdata = '0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_inst_ok", inst_ok, 1'b0);
    check("rst_data_ok", data_ok, 1'b0);
    check("rst_bus_wr", bus_wr, 1'b0);
    check("rst_bus_size", bus_size, 2'd0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_state", dbg_state, 2'd0);
    check("rst_own", dbg_own, 1'b0);
    check("rst_stall_idle", stall, 1'b0);
    inst_req = 1'b1; #1;
    check("rst_stall_req", stall, 1'b1);
    check("rst_no_bus_req", bus_req, 1'b0);
    inst_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Spurious slave handshakes while idle must be ignored.
    @(posedge clk); #1;
    bus_data_ok = 1'b1; bus_addr_ok = 1'b1; bus_rdata = 32'h5555_AAAA; #1;
    check("spur_inst_ok", inst_ok, 1'b0);
    check("spur_data_ok", data_ok, 1'b0);
    check("spur_bus_req", bus_req, 1'b0);
    @(posedge clk); #1;
    bus_data_ok = 1'b0; bus_addr_ok = 1'b0;
    check("spur_state", dbg_state, 2'd0);
    run_vec(10, vecs[3]);

    // Reset while waiting for data, then the still-pending fetch restarts cleanly.
    @(posedge clk); #1;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0200;
    @(posedge clk); #1;
    check("mr_bus_req", bus_req, 1'b1);
    bus_addr_ok = 1'b1;
    @(posedge clk); #1;
    bus_addr_ok = 1'b0;
    check("mr_in_wait", dbg_state, 2'd2);
    bus_data_ok = 1'b1; bus_rdata = 32'h1357_9BDF;
    rst = 1'b0; #1;
    check("mr_bus_req_rst", bus_req, 1'b0);
    check("mr_inst_ok_rst", inst_ok, 1'b0);
    check("mr_data_ok_rst", data_ok, 1'b0);
    check("mr_addr_rst", bus_addr, 32'h0);
    check("mr_stall_rst", stall, 1'b1);
    @(negedge clk);
    rst = 1'b1; bus_data_ok = 1'b0;
    @(posedge clk); #1;
    check("mr_restart_req", bus_req, 1'b1);
    check("mr_restart_addr", bus_addr, 32'hBFC0_0200);
    bus_addr_ok = 1'b1;
    @(posedge clk); #1;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h2468_ACE0; #1;
    check("mr_inst_ok", inst_ok, 1'b1);
    check("mr_inst_rdata", inst_rdata, 32'h2468_ACE0);
    check("mr_stall_done", stall, 1'b0);
    @(posedge clk); #1;
    inst_req = 1'b0; bus_data_ok = 1'b0;
    check("mr_idle", dbg_state, 2'd0);
    check("mr_ok_gone", inst_ok, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
